traffic_monitor: RTL and testbench

Passive observer on the lamp outputs of the traffic light controller. Samples red/yellow/green each clock, tracks the phase sequence RED -> YELLOW_1 -> GREEN -> YELLOW_2 -> RED, and measures per-phase dwell. Flags illegal lamp codes, out-of-order phases and wrong dwell lengths, and counts completed cycles. Sits beside the controller in the top level and in the bench as a protocol checker; it drives nothing back into the controller.

---
 rtl/traffic_pkg.sv | 42 ++++
 rtl/traffic_lamp_decode.sv | 33 +++
 rtl/traffic_monitor.sv | 150 +++++++++++++++
 tb/tb_traffic_monitor.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/traffic_pkg.sv
// Shared definitions for the traffic light controller and its lamp monitor:
// phase/lamp encodings, default dwell lengths and the monitor state type.
package traffic_pkg;

  localparam logic [1:0] PH_RED      = 2'd0;
  localparam logic [1:0] PH_YELLOW_1 = 2'd1;
  localparam logic [1:0] PH_GREEN    = 2'd2;
  localparam logic [1:0] PH_YELLOW_2 = 2'd3;

  localparam logic [2:0] LAMP_R = 3'b100;
  localparam logic [2:0] LAMP_Y = 3'b010;
  localparam logic [2:0] LAMP_G = 3'b001;

  localparam int DEF_RED_CYCLES    = 6;
  localparam int DEF_YELLOW_CYCLES = 2;
  localparam int DEF_GREEN_CYCLES  = 6;

  typedef enum logic [1:0] {
    KIND_R,
    KIND_Y,
    KIND_G
  } lamp_kind_e;

  typedef enum logic [2:0] {
    ST_SYNC,
    ST_RED,
    ST_Y1,
    ST_GRN,
    ST_Y2
  } mon_state_e;

  // SYNC reports phase 0; phase_valid tells it apart from RED.
  function automatic logic [1:0] state_phase(input mon_state_e s);
    case (s)
      ST_Y1:   return PH_YELLOW_1;
      ST_GRN:  return PH_GREEN;
      ST_Y2:   return PH_YELLOW_2;
      default: return PH_RED;
    endcase
  endfunction

endpackage

// File: rtl/traffic_lamp_decode.sv
// Registers the three lamp inputs and classifies the registered code as
// a single red, yellow or green lamp, or as an invalid (not one-hot) code.
module traffic_lamp_decode
  import traffic_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       red,
  input  logic       yellow,
  input  logic       green,
  output logic       lamp_valid,
  output lamp_kind_e lamp_kind
);

  logic [2:0] lamp_q;

  always_ff @(posedge clk) begin
    if (!rst) lamp_q <= 3'b000;
    else      lamp_q <= {red, yellow, green};
  end

  always_comb begin
    lamp_valid = 1'b1;
    lamp_kind  = KIND_R;
    case (lamp_q)
      LAMP_R:  lamp_kind = KIND_R;
      LAMP_Y:  lamp_kind = KIND_Y;
      LAMP_G:  lamp_kind = KIND_G;
      default: lamp_valid = 1'b0;
    endcase
  end

endmodule

// File: rtl/traffic_monitor.sv
// Passive checker on the controller's lamps: follows RED->Y1->GRN->Y2->RED,
// measures dwell per phase, raises sticky error flags and counts cycles.
module traffic_monitor
  import traffic_pkg::*;
#(
  parameter int RED_CYCLES    = DEF_RED_CYCLES,
  parameter int YELLOW_CYCLES = DEF_YELLOW_CYCLES,
  parameter int GREEN_CYCLES  = DEF_GREEN_CYCLES,
  parameter int CNT_W         = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             red,
  input  logic             yellow,
  input  logic             green,
  input  logic             err_clr,
  output logic [1:0]       phase,
  output logic             phase_valid,
  output logic [CNT_W-1:0] dwell,
  output logic             err_onehot,
  output logic             err_seq,
  output logic             err_dwell,
  output logic             cycle_done,
  output logic [15:0]      cycle_count,
  output mon_state_e       dbg_state
);

  localparam logic [CNT_W-1:0] RED_REQ = CNT_W'(RED_CYCLES);
  localparam logic [CNT_W-1:0] YEL_REQ = CNT_W'(YELLOW_CYCLES);
  localparam logic [CNT_W-1:0] GRN_REQ = CNT_W'(GREEN_CYCLES);
  localparam logic [CNT_W-1:0] DWELL_MAX = '1;

  logic       lamp_valid;
  lamp_kind_e lamp_kind;

  traffic_lamp_decode u_decode (
    .clk        (clk),
    .rst        (rst),
    .red        (red),
    .yellow     (yellow),
    .green      (green),
    .lamp_valid (lamp_valid),
    .lamp_kind  (lamp_kind)
  );

  mon_state_e       state_q, state_d, nxt_state;
  lamp_kind_e       cur_kind, nxt_kind;
  logic [CNT_W-1:0] req, dwell_d, dwell_inc;
  logic             partial_q, partial_d;
  logic             set_onehot, set_seq, set_dwell, done_d;

  // Lamp expected now, lamp that legally follows, and required dwell.
  always_comb begin
    cur_kind  = KIND_R;
    nxt_kind  = KIND_Y;
    nxt_state = ST_Y1;
    req       = RED_REQ;
    case (state_q)
      ST_Y1: begin
        cur_kind  = KIND_Y;
        nxt_kind  = KIND_G;
        nxt_state = ST_GRN;
        req       = YEL_REQ;
      end
      ST_GRN: begin
        cur_kind  = KIND_G;
        nxt_kind  = KIND_Y;
        nxt_state = ST_Y2;
        req       = GRN_REQ;
      end
      ST_Y2: begin
        cur_kind  = KIND_Y;
        nxt_kind  = KIND_R;
        nxt_state = ST_RED;
        req       = YEL_REQ;
      end
      default: ;
    endcase
  end

  assign dwell_inc = (dwell == DWELL_MAX) ? dwell : dwell + CNT_W'(1);

  always_comb begin
    state_d    = state_q;
    dwell_d    = dwell;
    partial_d  = partial_q;
    set_onehot = 1'b0;
    set_seq    = 1'b0;
    set_dwell  = 1'b0;
    done_d     = 1'b0;
    case (state_q)
      ST_SYNC: begin
        // The first red after locking is partial; its length is unknown.
        if (lamp_valid && lamp_kind == KIND_R) begin
          state_d   = ST_RED;
          dwell_d   = CNT_W'(1);
          partial_d = 1'b1;
        end
      end
      default: begin
        if (!lamp_valid) begin
          set_onehot = 1'b1;
          state_d    = ST_SYNC;
          dwell_d    = '0;
        end else if (lamp_kind == cur_kind) begin
          dwell_d = dwell_inc;
          if (dwell == req) set_dwell = 1'b1;
        end else if (lamp_kind == nxt_kind) begin
          state_d   = nxt_state;
          dwell_d   = CNT_W'(1);
          partial_d = 1'b0;
          if (dwell < req && !partial_q) set_dwell = 1'b1;
          if (state_q == ST_Y2) done_d = 1'b1;
        end else begin
          set_seq = 1'b1;
          state_d = ST_SYNC;
          dwell_d = '0;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= ST_SYNC;
      dwell       <= '0;
      partial_q   <= 1'b0;
      err_onehot  <= 1'b0;
      err_seq     <= 1'b0;
      err_dwell   <= 1'b0;
      cycle_done  <= 1'b0;
      cycle_count <= 16'd0;
    end else begin
      state_q    <= state_d;
      dwell      <= dwell_d;
      partial_q  <= partial_d;
      // A fresh detection takes priority over a clear in the same cycle.
      err_onehot <= set_onehot | (err_onehot & ~err_clr);
      err_seq    <= set_seq    | (err_seq    & ~err_clr);
      err_dwell  <= set_dwell  | (err_dwell  & ~err_clr);
      cycle_done <= done_d;
      if (done_d) cycle_count <= cycle_count + 16'd1;
    end
  end

  assign phase       = state_phase(state_q);
  assign phase_valid = (state_q != ST_SYNC);
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_traffic_monitor.sv
// Directed and randomized lamp streams for traffic_monitor, each clock checked
// against a phase-table reference model of the monitor's rules.
module tb_traffic_monitor;
  import traffic_pkg::*;

  localparam int CNT_W     = 8;
  localparam int DWELL_MAX = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             red = 1'b0, yellow = 1'b0, green = 1'b0;
  logic             err_clr = 1'b0;
  logic [1:0]       phase;
  logic             phase_valid;
  logic [CNT_W-1:0] dwell;
  logic             err_onehot, err_seq, err_dwell, cycle_done;
  logic [15:0]      cycle_count;
  mon_state_e       dbg_state;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  traffic_monitor #(
    .RED_CYCLES    (6),
    .YELLOW_CYCLES (2),
    .GREEN_CYCLES  (6),
    .CNT_W         (CNT_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .red         (red),
    .yellow      (yellow),
    .green       (green),
    .err_clr     (err_clr),
    .phase       (phase),
    .phase_valid (phase_valid),
    .dwell       (dwell),
    .err_onehot  (err_onehot),
    .err_seq     (err_seq),
    .err_dwell   (err_dwell),
    .cycle_done  (cycle_done),
    .cycle_count (cycle_count),
    .dbg_state   (dbg_state)
  );

  // ---------------- reference model ----------------
  int         req_tab [4] = '{6, 2, 6, 2};
  logic [2:0] lamp_tab[4] = '{3'b100, 3'b010, 3'b001, 3'b010};

  int          m_phase;   // -1 while unlocked, else index into the tables
  int          m_dwell;
  bit          m_partial, m_err_oh, m_err_seq, m_err_dw, m_done;
  logic [15:0] m_count;
  logic [2:0]  m_lamp_q;

  int    checks = 0;
  int    errors = 0;
  string cur_step = "init";

  task automatic model_step(input logic [2:0] code_in, input bit clr, input bit rst_n);
    logic [2:0] q;
    bit e_oh, e_seq, e_dw;
    if (!rst_n) begin
      m_phase = -1; m_dwell = 0; m_partial = 0;
      m_err_oh = 0; m_err_seq = 0; m_err_dw = 0;
      m_done = 0; m_count = 16'd0; m_lamp_q = 3'b000;
      return;
    end
    q = m_lamp_q;
    e_oh = 0; e_seq = 0; e_dw = 0;
    m_done = 0;
    if (m_phase < 0) begin
      if (q == 3'b100) begin
        m_phase = 0; m_dwell = 1; m_partial = 1;
      end
    end else if ($countones(q) != 1) begin
      e_oh = 1; m_phase = -1; m_dwell = 0;
    end else if (q == lamp_tab[m_phase]) begin
      if (m_dwell < DWELL_MAX) begin
        m_dwell++;
        if (m_dwell == req_tab[m_phase] + 1) e_dw = 1;
      end
    end else if (q == lamp_tab[(m_phase + 1) % 4]) begin
      if (m_dwell < req_tab[m_phase] && !m_partial) e_dw = 1;
      m_partial = 0;
      if (m_phase == 3) begin
        m_done = 1;
        m_count++;
      end
      m_phase = (m_phase + 1) % 4;
      m_dwell = 1;
    end else begin
      e_seq = 1; m_phase = -1; m_dwell = 0;
    end
    m_err_oh  = e_oh  | (m_err_oh  & !clr);
    m_err_seq = e_seq | (m_err_seq & !clr);
    m_err_dw  = e_dw  | (m_err_dw  & !clr);
    m_lamp_q  = code_in;
  endtask

  // ---------------- scoreboard ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s.%s: observed %0h expected %0h", cur_step, tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("phase",       32'(phase),       (m_phase < 0) ? 32'd0 : 32'(m_phase));
    chk("phase_valid", 32'(phase_valid), 32'(m_phase >= 0));
    chk("dwell",       32'(dwell),       32'(m_dwell));
    chk("err_onehot",  32'(err_onehot),  32'(m_err_oh));
    chk("err_seq",     32'(err_seq),     32'(m_err_seq));
    chk("err_dwell",   32'(err_dwell),   32'(m_err_dw));
    chk("cycle_done",  32'(cycle_done),  32'(m_done));
    chk("cycle_count", 32'(cycle_count), 32'(m_count));
    chk("dbg_sync",    32'(dbg_state == ST_SYNC), 32'(m_phase < 0));
  endtask

  // ---------------- drivers ----------------
  task automatic drive(input logic [2:0] code, input bit clr = 1'b0, input bit rst_n = 1'b1);
    {red, yellow, green} = code;
    err_clr = clr;
    rst     = rst_n;
    model_step(code, clr, rst_n);
    @(posedge clk);
    #1;
    check_all();
    err_clr = 1'b0;
  endtask

  task automatic hold(input logic [2:0] code, input int n);
    repeat (n) drive(code);
  endtask

  localparam logic [2:0] R = 3'b100, Y = 3'b010, G = 3'b001;

  // ---------------- stimulus ----------------
  initial begin
    @(posedge clk);
    #1;

    cur_step = "reset";
    repeat (3) drive(3'b000, 1'b0, 1'b0);
    chk("rst_phase_valid", 32'(phase_valid), 32'd0);
    chk("rst_count",       32'(cycle_count), 32'd0);
    hold(3'b000, 2);

    cur_step = "legal";
    drive(R);
    chk("not_locked_yet", 32'(phase_valid), 32'd0);
    drive(R);
    chk("locked", 32'(phase_valid), 32'd1);
    hold(R, 4); hold(Y, 2); hold(G, 6); hold(Y, 2);
    drive(R);
    drive(R);
    chk("done_pulse", 32'(cycle_done), 32'd1);
    hold(R, 4);
    chk("count_one", 32'(cycle_count), 32'd1);
    chk("no_dwell_err", 32'(err_dwell), 32'd0);

    cur_step = "green_long";
    hold(Y, 2); hold(G, 7);
    drive(Y);
    chk("overrun", 32'(err_dwell), 32'd1);
    drive(Y);
    hold(R, 6); hold(Y, 2); hold(G, 6); hold(Y, 2);
    chk("sticky", 32'(err_dwell), 32'd1);

    cur_step = "red_short";
    hold(R, 5);
    drive(R, 1'b1);
    chk("cleared", 32'(err_dwell), 32'd0);
    hold(Y, 2); hold(G, 6); hold(Y, 2); hold(R, 4);
    hold(Y, 2);
    chk("underrun", 32'(err_dwell), 32'd1);

    cur_step = "onehot";
    hold(G, 3);
    drive(3'b110);
    drive(3'b000);
    chk("onehot_set", 32'(err_onehot),  32'd1);
    chk("onehot_sync", 32'(phase_valid), 32'd0);
    chk("onehot_dwell", 32'(dwell),      32'd0);

    cur_step = "partial_red";
    drive(R, 1'b1);
    hold(R, 2); hold(Y, 2);
    chk("partial_ok", 32'(err_dwell), 32'd0);
    hold(G, 6); hold(Y, 2); hold(R, 6);
    chk("partial_cycle_ok", 32'(err_dwell), 32'd0);

    cur_step = "seq";
    hold(G, 2);
    chk("seq_set", 32'(err_seq), 32'd1);
    drive(3'b000, 1'b1);
    chk("seq_cleared", 32'(err_seq), 32'd0);
    hold(R, 6); hold(Y, 2); hold(G, 3);
    drive(3'b000);
    drive(G, 1'b1);
    chk("clr_vs_detect", 32'(err_onehot), 32'd1);

    cur_step = "saturate";
    hold(R, 300);
    chk("dwell_sat", 32'(dwell), 32'(DWELL_MAX));
    chk("sat_err", 32'(err_dwell), 32'd1);

    cur_step = "wrap";
    drive(R, 1'b1);
    hold(Y, 2); hold(G, 6); hold(Y, 2);
    force dut.cycle_count = 16'hFFFF;
    #1;
    release dut.cycle_count;
    m_count = 16'hFFFF;
    hold(R, 2);
    chk("wrap_zero", 32'(cycle_count), 32'd0);
    chk("wrap_done", 32'(cycle_done), 32'd1);

    cur_step = "rst_mid_green";
    hold(R, 4); hold(Y, 2); hold(G, 3);
    drive(G, 1'b0, 1'b0);
    chk("mid_valid", 32'(phase_valid), 32'd0);
    chk("mid_dwell", 32'(dwell), 32'd0);
    chk("mid_count", 32'(cycle_count), 32'd0);
    hold(3'b000, 1);

    cur_step = "random";
    for (int c = 0; c < 30; c++) begin
      for (int p = 0; p < 4; p++) begin
        int n;
        n = req_tab[p] + int'($urandom_range(0, 2)) - 1;
        for (int k = 0; k < n; k++) begin
          logic [2:0] code;
          code = lamp_tab[p];
          if ($urandom_range(0, 19) == 0) code = 3'($urandom_range(0, 7));
          drive(code, $urandom_range(0, 9) == 0);
        end
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
